// File: rtl/ram_access_ctrl.sv
// Button/switch driven access controller for the 256x16 single-port lab RAM.
// Optional auto-scan stepping is built only when AUTO_SCAN_EN is defined.
module ram_access_ctrl #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int SCAN_DIV = 50000000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] sw_data,
  input  logic          wr_req,
  input  logic          addr_inc,
  input  logic          addr_dec,
  input  logic          scan,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic [DW-1:0] disp_data,
  output logic [AW-1:0] disp_addr,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, WRITE} state_t;
  typedef enum logic [1:0] {ACT_NONE, ACT_WR, ACT_INC, ACT_DEC} act_t;

  state_t state, state_nxt;
  act_t   act;
  logic   scan_tick;

`ifdef AUTO_SCAN_EN
  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  logic [CW-1:0] scan_cnt;

  assign scan_tick = scan && (scan_cnt == CW'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
    end else if (!scan || scan_tick) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end
`else
  logic unused_scan;
  assign unused_scan = scan;
  assign scan_tick   = 1'b0;
`endif

  // Request arbitration happens only in IDLE; anything arriving while busy is lost.
  always_comb begin
    state_nxt = state;
    act       = ACT_NONE;
    case (state)
      IDLE: begin
        if (wr_req) begin
          act       = ACT_WR;
          state_nxt = WRITE;
        end else if (addr_inc) begin
          act       = ACT_INC;
          state_nxt = FETCH;
        end else if (addr_dec) begin
          act       = ACT_DEC;
          state_nxt = FETCH;
        end else if (scan_tick) begin
          act       = ACT_INC;
          state_nxt = FETCH;
        end
      end
      FETCH:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      WRITE:   state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Starting in FETCH makes the first cycles after reset a read of address 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      disp_data <= '0;
      disp_addr <= '0;
    end else begin
      ram_we <= (act == ACT_WR);
      case (act)
        ACT_WR:  ram_din  <= sw_data;
        ACT_INC: ram_addr <= ram_addr + AW'(1);
        ACT_DEC: ram_addr <= ram_addr - AW'(1);
        default: ;
      endcase
      if (state == CAPTURE) begin
        disp_data <= ram_dout;
        disp_addr <= ram_addr;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Initiator-side controller for the 256×16 single-port synchronous lab RAM. It drives the RAM's clock-domain port signals (we, addr, din) and consumes its dout. It turns debounced one-cycle button pulses and the 16 slide switches into write, read-back and address-step transactions, and holds the last read word and its address for the seven-segment display path.

## Interface
Parameters:
- AW, 8, RAM address width; the address space is 2^AW words.
- DW, 16, RAM data width; matches the slide-switch count.
- SCAN_DIV, 50000000, clock cycles between auto-scan steps. Must be ≥ 4. Used only when AUTO_SCAN_EN is defined.

Ports:
- clk, input, 1, system clock. All logic is rising-edge.
- reset, input, 1, asynchronous, active-high reset.
- sw_data, input, DW, write data from the slide switches. Sampled only on an accepted write.
- wr_req, input, 1, one-cycle pulse (debounced button): write sw_data at the current address.
- addr_inc, input, 1, one-cycle pulse: current address +1, then read.
- addr_dec, input, 1, one-cycle pulse: current address −1, then read.
- scan, input, 1, level: enables auto-scan. Ignored when AUTO_SCAN_EN is not defined.
- ram_we, output, 1, RAM write enable. Registered.
- ram_addr, output, AW, RAM address. Registered; this is the current address.
- ram_din, output, DW, RAM write data. Registered.
- ram_dout, input, DW, RAM read data. The RAM has 1-cycle read latency: the address is registered at edge N and data is valid after edge N.
- disp_data, output, DW, last word captured from the RAM.
- disp_addr, output, AW, address disp_data was read from.
- busy, output, 1, high whenever state ≠ IDLE.

## Operation
- States:
  - FETCH: ram_addr held, ram_we=0.
  - CAPTURE: ram_dout valid; disp_data and disp_addr are loaded at the end of this cycle.
  - WRITE: ram_we=1 for exactly one cycle.
  - IDLE.
- Transitions:
  - FETCH → CAPTURE → IDLE unconditionally.
  - WRITE → FETCH, so every write is followed by a read-back of the same address.
- IDLE acceptance, one request per edge, priority wr_req > addr_inc > addr_dec > scan tick:
  - wr_req: ram_din ← sw_data, ram_we ← 1, go to WRITE. ram_addr is unchanged.
  - addr_inc: ram_addr ← ram_addr+1, go to FETCH.
  - addr_dec: ram_addr ← ram_addr−1, go to FETCH.
  - Address arithmetic is modulo 2^AW: 255+1 → 0 and 0−1 → 255.
- Requests arriving while busy=1 are dropped. They are not queued. Lower-priority requests coinciding with an accepted one are also dropped.
- ram_din keeps its last written value; it is not cleared after a write.
- Reset (asynchronous, any state, including mid-write):
  - ram_we=0, ram_addr=0, ram_din=0, disp_data=0, disp_addr=0, scan counter=0, state=FETCH, busy=1.
  - After release the block reads address 0 automatically.
  - A reset asserted during WRITE deasserts ram_we immediately. Whether the RAM commits that word is unspecified.

## Timing
Edge E0 is the edge at which a request is accepted in IDLE.
- Write: ram_we is high E0→E1, and the RAM writes at E1. FETCH runs E1→E2 and CAPTURE runs E2→E3. disp_data equals the written word after E3. busy is high E0→E3, so the write round trip is 3 cycles.
- Inc/dec: ram_addr changes at E0. disp_data and disp_addr update at E2. busy is high E0→E2, 2 cycles.
- After reset release: disp_data = mem[0] after the 2nd rising edge.
- disp_data and disp_addr change only at the end of CAPTURE.

## Configuration
- AUTO_SCAN_EN defined:
  - A free-running counter counts 0..SCAN_DIV−1 while scan=1 and resets to 0 while scan=0.
  - When the counter reaches SCAN_DIV−1 it raises a scan tick.
  - A tick in IDLE acts as addr_inc. A tick while busy is dropped.
  - Result: the block cycles through the whole memory once per 256·SCAN_DIV cycles, approximately.
- AUTO_SCAN_EN not defined: the counter is not built and the scan port is ignored. Behaviour is otherwise identical.

## Test plan
- Reset, with mem[0]=16'hBEEF preloaded, then release → busy falls after 2 edges; disp_data=16'hBEEF, disp_addr=0; ram_we never asserted.
- sw_data=16'h1234, wr_req pulse at address 0 → ram_we high exactly 1 cycle with ram_din=16'h1234, ram_addr=0; disp_data=16'h1234 three edges after acceptance.
- addr_dec pulse at address 0 → ram_addr=8'hFF; disp_addr=8'hFF after 2 edges. Then addr_inc → ram_addr=0 (wrap both directions).
- wr_req and addr_inc in the same cycle, followed by addr_inc while busy → write at the original address only; both addr_inc pulses dropped; ram_addr unchanged.
- reset asserted during the WRITE cycle → ram_we, ram_addr and disp_data go to 0 without waiting for a clock edge; after release, mem[0] is read back normally.
- AUTO_SCAN_EN with SCAN_DIV=4 and scan=1 for 40 cycles → ram_addr advances once every 4 cycles, since each 2-cycle fetch fits inside the tick interval. With scan=0, or without the macro, ram_addr stays fixed.
